// File: rtl/otter_rf_pkg.sv
// Shared types and defaults for the OTTER register file with hazard scoreboard.
package otter_rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int RF_XLEN_DEF  = 32;
  localparam int RF_NREGS_DEF = 32;

  function automatic int rf_adr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write tracker: one busy flop per register, set on issue, cleared on writeback.
module rf_scoreboard
  import otter_rf_pkg::*;
#(
  parameter int NREGS = RF_NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = rf_adr_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              set_vld,
  input  logic [AW-1:0]     set_rd,
  input  logic              clr_vld,
  input  logic [AW-1:0]     clr_rd,
  input  logic [NRD*AW-1:0] lookup_adr,
  output logic [NRD-1:0]    busy
);

  logic [NREGS-1:0] r_busy;

  // A set and a clear of the same register in one cycle keep it busy:
  // the issue belongs to a newer producer than the retiring write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else if (run) begin
      r_busy[0] <= 1'b0;
      for (int i = 1; i < NREGS; i++) begin
        if (set_vld && (set_rd == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (clr_vld && (clr_rd == AW'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int p = 0; p < NRD; p++) begin
      busy[p] = r_busy[lookup_adr[p*AW +: AW]];
    end
  end

endmodule

// File: rtl/otter_rf_scoreboard.sv
// OTTER register file: NRD async reads, one sync write, optional bypass,
// post-reset clear sequencer so the array itself carries no reset.
module otter_rf_scoreboard
  import otter_rf_pkg::*;
#(
  parameter  int XLEN   = RF_XLEN_DEF,
  parameter  int NREGS  = RF_NREGS_DEF,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = rf_adr_w(NREGS)
) (
  input  logic                RF_CLK,
  input  logic                RF_RST,
  input  logic [NRD*AW-1:0]   RF_ADR,
  output logic [NRD*XLEN-1:0] RF_RS,
  output logic [NRD-1:0]      RF_BUSY,
  input  logic [AW-1:0]       RF_WA,
  input  logic [XLEN-1:0]     RF_WD,
  input  logic                RF_EN,
  input  logic                RF_ISSUE,
  input  logic [AW-1:0]       RF_ISSUE_RD,
  output logic                RF_READY,
  output rf_state_t           RF_DBG_STATE
);

  rf_state_t       r_state;
  logic [AW-1:0]   r_clr_cnt;
  logic [XLEN-1:0] r_ram [NREGS];

  logic            w_run;
  logic            w_wr_ok;
  logic            w_ram_we;
  logic [AW-1:0]   w_ram_wa;
  logic [XLEN-1:0] w_ram_wd;
  logic            w_set_vld;
  logic [NRD-1:0]  w_busy;

  // Entry 0 is never stored; reads of address 0 are forced to zero.
  always_ff @(posedge RF_CLK) begin
    if (RF_RST) begin
      r_state   <= CLEAR;
      r_clr_cnt <= AW'(1);
    end else if (r_state == CLEAR) begin
      r_clr_cnt <= r_clr_cnt + AW'(1);
      if (r_clr_cnt == AW'(NREGS - 1)) begin
        r_state <= RUN;
      end
    end
  end

  assign w_run     = (r_state == RUN);
  assign w_wr_ok   = w_run && RF_EN && (RF_WA != '0);
  assign w_set_vld = w_run && RF_ISSUE && (RF_ISSUE_RD != '0);
  assign w_ram_we  = !RF_RST && ((r_state == CLEAR) || w_wr_ok);
  assign w_ram_wa  = w_run ? RF_WA : r_clr_cnt;
  assign w_ram_wd  = w_run ? RF_WD : '0;

  // Single write port shared by the clear sequencer and writeback.
  always_ff @(posedge RF_CLK) begin
    if (w_ram_we) begin
      r_ram[w_ram_wa] <= w_ram_wd;
    end
  end

  always_comb begin
    RF_RS = '0;
    for (int p = 0; p < NRD; p++) begin
      if (w_run && (RF_ADR[p*AW +: AW] != '0)) begin
        if ((BYPASS != 0) && RF_EN && (RF_WA == RF_ADR[p*AW +: AW])) begin
          RF_RS[p*XLEN +: XLEN] = RF_WD;
        end else begin
          RF_RS[p*XLEN +: XLEN] = r_ram[RF_ADR[p*AW +: AW]];
        end
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk        (RF_CLK),
    .rst        (RF_RST),
    .run        (w_run),
    .set_vld    (w_set_vld),
    .set_rd     (RF_ISSUE_RD),
    .clr_vld    (w_wr_ok),
    .clr_rd     (RF_WA),
    .lookup_adr (RF_ADR),
    .busy       (w_busy)
  );

  assign RF_BUSY      = w_run ? w_busy : '0;
  assign RF_READY     = w_run;
  assign RF_DBG_STATE = r_state;

endmodule

// File: tb/tb_otter_rf_scoreboard.sv
// Randomized scoreboard bench for two register-file configurations driven in lockstep.
module tb_otter_rf_scoreboard;
  import otter_rf_pkg::*;

  localparam int EW = 261;

  logic clk;
  int   total;
  int   bad;

  // Instance A: defaults (XLEN=32, NREGS=32, NRD=2, BYPASS=1)
  logic        rst_a, en_a, iss_a, rdy_a;
  logic [9:0]  adr_a;
  logic [63:0] rs_a;
  logic [1:0]  busy_a;
  logic [4:0]  wa_a, ird_a;
  logic [31:0] wd_a;
  rf_state_t   st_a;

  // Instance B: XLEN=64, NREGS=16, NRD=3, BYPASS=0
  logic         rst_b, en_b, iss_b, rdy_b;
  logic [11:0]  adr_b;
  logic [191:0] rs_b;
  logic [2:0]   busy_b;
  logic [3:0]   wa_b, ird_b;
  logic [63:0]  wd_b;
  rf_state_t    st_b;

  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];

  logic [63:0] m_ram [2][32];
  bit          m_busy[2][32];
  int          m_left[2];

  otter_rf_scoreboard dut_a (
    .RF_CLK(clk), .RF_RST(rst_a), .RF_ADR(adr_a), .RF_RS(rs_a), .RF_BUSY(busy_a),
    .RF_WA(wa_a), .RF_WD(wd_a), .RF_EN(en_a), .RF_ISSUE(iss_a),
    .RF_ISSUE_RD(ird_a), .RF_READY(rdy_a), .RF_DBG_STATE(st_a)
  );

  otter_rf_scoreboard #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(0)) dut_b (
    .RF_CLK(clk), .RF_RST(rst_b), .RF_ADR(adr_b), .RF_RS(rs_b), .RF_BUSY(busy_b),
    .RF_WA(wa_b), .RF_WD(wd_b), .RF_EN(en_b), .RF_ISSUE(iss_b),
    .RF_ISSUE_RD(ird_b), .RF_READY(rdy_b), .RF_DBG_STATE(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus into instance d, queue the expected outputs
  // for this cycle, then advance the reference model across the coming edge.
  task automatic drv(input int d, input logic rst, input logic en, input logic [4:0] wa_i,
                     input logic [63:0] wd, input logic iss, input logic [4:0] ird_i,
                     input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    int          n, nrd;
    logic [4:0]  mk, wa, ird;
    logic [4:0]  ad[3];
    logic [63:0] wdm, v;
    logic [255:0] rs;
    logic [3:0]  bz;
    logic        rdy;
    n   = (d == 0) ? 32 : 16;
    nrd = (d == 0) ? 2 : 3;
    mk  = 5'(n - 1);
    wa  = wa_i & mk;
    ird = ird_i & mk;
    ad[0] = a0 & mk;
    ad[1] = a1 & mk;
    ad[2] = a2 & mk;
    wdm = (d == 0) ? {32'h0, wd[31:0]} : wd;
    if (d == 0) begin
      rst_a = rst; en_a = en; wa_a = wa; wd_a = wd[31:0];
      iss_a = iss; ird_a = ird; adr_a = {ad[1], ad[0]};
    end else begin
      rst_b = rst; en_b = en; wa_b = wa[3:0]; wd_b = wd;
      iss_b = iss; ird_b = ird[3:0]; adr_b = {ad[2][3:0], ad[1][3:0], ad[0][3:0]};
    end
    if (!rst) begin
      rdy = (m_left[d] == 0);
      rs  = '0;
      bz  = '0;
      if (rdy) begin
        for (int p = 0; p < nrd; p++) begin
          if (ad[p] == 5'd0) v = '0;
          else if (d == 0 && en && wa == ad[p]) v = wdm;
          else v = m_ram[d][ad[p]];
          bz[p] = m_busy[d][ad[p]];
          if (d == 0) rs[p*32 +: 32] = v[31:0];
          else        rs[p*64 +: 64] = v;
        end
      end
      if (d == 0) exp_a_q.push_back({rdy, bz, rs});
      else        exp_b_q.push_back({rdy, bz, rs});
    end
    if (rst) begin
      m_left[d] = n - 1;
      for (int i = 0; i < 32; i++) begin
        m_ram[d][i]  = '0;
        m_busy[d][i] = 1'b0;
      end
    end else if (m_left[d] > 0) begin
      m_left[d]--;
    end else begin
      if (en && wa != 5'd0) begin
        m_ram[d][wa]  = wdm;
        m_busy[d][wa] = 1'b0;
      end
      if (iss && ird != 5'd0) m_busy[d][ird] = 1'b1;
    end
  endtask

  task automatic drv_rand(input int d);
    logic [4:0] wa;
    wa = 5'($urandom_range(0, 31));
    drv(d, 1'b0, 1'($urandom_range(0, 1)), wa, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
        5'($urandom_range(0, 31)),
        ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
        ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
        5'($urandom_range(0, 31)));
  endtask

  task automatic rd_a(input logic [4:0] a0, input logic [4:0] a1);
    drv(0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, a0, a1, 5'd0);
  endtask

  // monitor: pops one expectation per instance per cycle
  always @(negedge clk) begin
    logic [EW-1:0] e, act;
    if (exp_a_q.size() > 0) begin
      e   = exp_a_q.pop_front();
      act = {rdy_a, 2'b00, busy_a, 192'h0, rs_a};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL inst_a t=%0t ready got=%b exp=%b busy got=%h exp=%h rs got=%h exp=%h",
                 $time, act[260], e[260], act[259:256], e[259:256], act[63:0], e[63:0]);
      end
    end
    if (exp_b_q.size() > 0) begin
      e   = exp_b_q.pop_front();
      act = {rdy_b, 1'b0, busy_b, 64'h0, rs_b};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL inst_b t=%0t ready got=%b exp=%b busy got=%h exp=%h rs got=%h exp=%h",
                 $time, act[260], e[260], act[259:256], e[259:256], act[191:0], e[191:0]);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    // reset both; random activity during CLEAR must be ignored
    drv(0, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    drv(1, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    for (int c = 0; c < 40; c++) begin
      tick(); drv_rand(0); drv_rand(1);
    end
    // fill A with all-ones and busy bits, then reset twice (second one mid-clear)
    for (int r = 0; r < 32; r++) begin
      tick();
      drv(0, 1'b0, 1'b1, 5'(r), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'(r), 5'(r), 5'(31 - r), 5'd0);
      drv_rand(1);
    end
    tick(); drv(0, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0); drv_rand(1);
    for (int c = 0; c < 11; c++) begin
      tick(); drv_rand(0); drv_rand(1);
    end
    tick(); drv(0, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0); drv_rand(1);
    for (int c = 0; c < 31; c++) begin
      tick(); drv_rand(0); drv_rand(1);
    end
    for (int r = 0; r < 32; r++) begin
      tick(); rd_a(5'(r), 5'(31 - r)); drv_rand(1);
    end
    // directed: write/read, x0, bypass, scoreboard set/clear priority
    tick(); drv(0, 1'b0, 1'b1, 5'd5, 64'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd3, 5'd0); drv_rand(1);
    tick(); rd_a(5'd5, 5'd5); drv_rand(1);
    tick(); drv(0, 1'b0, 1'b1, 5'd0, 64'h12345678, 1'b1, 5'd0, 5'd0, 5'd5, 5'd0); drv_rand(1);
    tick(); rd_a(5'd0, 5'd0); drv_rand(1);
    tick(); drv(0, 1'b0, 1'b1, 5'd9, 64'hA5A5A5A5, 1'b0, 5'd0, 5'd5, 5'd9, 5'd0); drv_rand(1);
    tick(); drv(0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd7, 5'd9, 5'd0); drv_rand(1);
    tick(); drv(0, 1'b0, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 5'd7, 5'd7, 5'd0); drv_rand(1);
    tick(); drv(0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd7, 5'd0, 5'd0); drv_rand(1);
    tick(); drv(0, 1'b0, 1'b1, 5'd7, 64'h78, 1'b1, 5'd7, 5'd7, 5'd7, 5'd0); drv_rand(1);
    tick(); rd_a(5'd7, 5'd7); drv_rand(1);
    // directed on B: no bypass, old value this cycle, new value next
    tick(); drv_rand(0); drv(1, 1'b0, 1'b1, 5'd9, 64'hA5A5A5A5_5A5A5A5A, 1'b0, 5'd0, 5'd9, 5'd9, 5'd1);
    tick(); drv_rand(0); drv(1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 5'd9, 5'd2, 5'd3);
    tick(); drv_rand(0); drv(1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd2, 5'd9, 5'd0);
    for (int c = 0; c < 1500; c++) begin
      tick(); drv_rand(0); drv_rand(1);
    end
    tick(); rd_a(5'd1, 5'd2); drv(1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd1, 5'd2, 5'd3);
    repeat (3) @(negedge clk);
    total++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d pending exp=0", exp_a_q.size(), exp_b_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
